// File: rtl/bcd_convert_seq_if.sv
// Request/result bundle for the sequential binary-to-BCD converter.
// The master issues start/bin_in and the slave returns status plus the BCD digits.
interface bcd_convert_seq_if #(
    parameter int IN_W = 8
);
    logic            start;
    logic [IN_W-1:0] bin_in;
    logic            busy;
    logic            done;
    logic [3:0]      ONES;
    logic [3:0]      TENS;
    logic [3:0]      HUNDREDS;

    modport master (
        output start, bin_in,
        input  busy, done, ONES, TENS, HUNDREDS
    );

    modport slave (
        input  start, bin_in,
        output busy, done, ONES, TENS, HUNDREDS
    );
endinterface

// File: rtl/bcd_convert_seq.sv
// Sequential double-dabble converter: one operand bit per clock, result in 3 BCD digits.
// Optional one-deep request buffer enabled by defining BCD_PENDING_EN.
module bcd_convert_seq #(
    parameter int IN_W = 8
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    bcd_convert_seq_if.slave   bus
);
    localparam int CNT_W = $clog2(IN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state, state_nxt;
    logic [IN_W-1:0]   shreg;
    logic [CNT_W-1:0]  cnt;
    logic [3:0]        w2, w1, w0;
    logic [3:0]        c2, c1, c0;
    logic [3:0]        w2_sh, w1_sh, w0_sh;
    logic [3:0]        ones_q, tens_q, hund_q;
    logic              load, load_pend, last;
    logic              pend_valid;
    logic [IN_W-1:0]   pend_data;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Shared correction stage followed by the one-bit chain shift
    always_comb begin
        c2    = add3(w2);
        c1    = add3(w1);
        c0    = add3(w0);
        w2_sh = {c2[2:0], c1[3]};
        w1_sh = {c1[2:0], c0[3]};
        w0_sh = {c0[2:0], shreg[IN_W-1]};
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_pend = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (pend_valid) begin
                    load      = 1'b1;
                    load_pend = 1'b1;
                    state_nxt = SHIFT;
                end else if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CNT_W'(IN_W - 1)) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                if (pend_valid) begin
                    load      = 1'b1;
                    load_pend = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            shreg  <= '0;
            cnt    <= '0;
            w2     <= '0;
            w1     <= '0;
            w0     <= '0;
            ones_q <= '0;
            tens_q <= '0;
            hund_q <= '0;
        end else if (load) begin
            shreg <= load_pend ? pend_data : bus.bin_in;
            cnt   <= '0;
            w2    <= '0;
            w1    <= '0;
            w0    <= '0;
        end else if (state == SHIFT) begin
            shreg <= {shreg[IN_W-2:0], 1'b0};
            cnt   <= cnt + 1'b1;
            w2    <= w2_sh;
            w1    <= w1_sh;
            w0    <= w0_sh;
            if (last) begin
                hund_q <= w2_sh;
                tens_q <= w1_sh;
                ones_q <= w0_sh;
            end
        end
    end

`ifdef BCD_PENDING_EN
    // A request arriving while busy is parked; the DONE-cycle slot frees as it is consumed
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            pend_valid <= 1'b0;
        end else begin
            if (load_pend)
                pend_valid <= 1'b0;
            if (bus.start && (state != IDLE) && (!pend_valid || load_pend)) begin
                pend_valid <= 1'b1;
                pend_data  <= bus.bin_in;
            end
        end
    end
`else
    assign pend_valid = 1'b0;
    assign pend_data  = '0;
`endif

    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);
    assign bus.ONES     = ones_q;
    assign bus.TENS     = tens_q;
    assign bus.HUNDREDS = hund_q;
endmodule
